// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state, opcode and mux-select encodings shared by the multicycle MIPS control and datapath.
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;
endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: combinational state -> control-word decode for the multicycle MIPS control.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: ctrl_o.alu_src_b = SRCB_BRIMM;
      S_MEMADR, S_ADDIEXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: ctrl_o.iord = 1'b1;
      S_MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.branch    = 1'b1;
      end
      S_ADDIWB: ctrl_o.reg_write = 1'b1;
      S_JUMP: begin
        ctrl_o.pc_src   = PCSRC_JUMP;
        ctrl_o.pc_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multicycle MIPS datapath (state register, sequencing, pc_en gate).
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  op,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            iord,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [SELW-1:0] alu_src_b,
  output logic [SELW-1:0] alu_op,
  output logic [SELW-1:0] pc_src,
  output logic            pc_en,
  output logic            illegal_op,
  output logic [3:0]      state_dbg
);
  state_e state_q, state_d;
  logic   illegal;
  ctrl_t  ctrl, ctrl_g;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  always_comb begin
    state_d = S_FETCH;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      illegal = 1'b1;
        endcase
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end
  mips_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );
  // FETCH would otherwise strobe ir_write/pc_write from mem_ready while reset is held
  assign ctrl_g     = rst_n ? ctrl : '0;
  assign iord       = ctrl_g.iord;
  assign mem_write  = ctrl_g.mem_write;
  assign ir_write   = ctrl_g.ir_write;
  assign reg_dst    = ctrl_g.reg_dst;
  assign mem_to_reg = ctrl_g.mem_to_reg;
  assign reg_write  = ctrl_g.reg_write;
  assign alu_src_a  = ctrl_g.alu_src_a;
  assign alu_src_b  = ctrl_g.alu_src_b;
  assign alu_op     = ctrl_g.alu_op;
  assign pc_src     = ctrl_g.pc_src;
  assign pc_en      = ctrl_g.pc_write | (ctrl_g.branch & zero);
  assign illegal_op = rst_n & illegal;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed vector table, reset corner cases and random instruction streams vs a plan-based model.
module tb_mips_multicycle_ctrl;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [5:0] op = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_dbg;
  typedef struct packed {
    logic iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic pc_en, illegal_op;
    logic [3:0] st;
  } outs_t;
  typedef struct {
    logic [5:0] op;
    logic z, mr;
    int   st;
    logic pc, ir, rw, mw, il;
  } vec_t;
  outs_t dut_o;
  vec_t  vecs[$];
  int    errors = 0, checks = 0;
  int    mst = 0;
  int    plan[$];
  assign dut_o = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_src, pc_en, illegal_op, state_dbg};
  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  function automatic outs_t expect_o(int st, logic [5:0] o, logic z, logic mr);
    outs_t e = '0;
    e.st = 4'(st);
    case (st)
      0: begin e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
      1: begin e.alu_src_b = 2'b11; e.illegal_op = !(o inside {LW, SW, RT, BEQ, ADDI, JMP}); end
      2, 9: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      3: e.iord = 1'b1;
      4: begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
      5: begin e.iord = 1'b1; e.mem_write = 1'b1; end
      6: begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
      7: begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
      8: begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z; end
      10: e.reg_write = 1'b1;
      11: begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction
  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", n, $time, got, exp);
    end
  endtask
  // After FETCH, the instruction is a fixed list of states chosen at DECODE from the opcode.
  task automatic model_step(input logic [5:0] o, input logic mr);
    if (mst == 1)
      case (o)
        LW:      plan = '{2, 3, 4};
        SW:      plan = '{2, 5};
        RT:      plan = '{6, 7};
        BEQ:     plan = '{8};
        ADDI:    plan = '{9, 10};
        JMP:     plan = '{11};
        default: plan = {};
      endcase
    if (!(mst inside {0, 3, 5}) || mr)
      mst = (mst == 0) ? 1 : (plan.size() > 0 ? plan.pop_front() : 0);
  endtask
  task automatic apply(input logic [5:0] o, input logic z, input logic mr);
    op = o; zero = z; mem_ready = mr;
    @(negedge clk);
    check("model", 32'(dut_o), 32'(expect_o(mst, o, z, mr)));
  endtask
  task automatic advance();
    @(posedge clk);
    model_step(op, mem_ready);
    #1;
  endtask
  task automatic do_reset();
    op = LW; zero = 1'b0; mem_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    check("in_reset", 32'(dut_o), 32'h0);
    mst = 0; plan = {};
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic add(input logic [5:0] o, input logic z, input logic mr, input int st,
                     input logic pc, input logic ir, input logic rw, input logic mw, input logic il);
    vec_t v;
    v.op = o; v.z = z; v.mr = mr; v.st = st; v.pc = pc; v.ir = ir; v.rw = rw; v.mw = mw; v.il = il;
    vecs.push_back(v);
  endtask
  initial begin
    add(LW, 0, 1, 0, 1, 1, 0, 0, 0); add(LW, 0, 1, 1, 0, 0, 0, 0, 0); add(LW, 0, 1, 2, 0, 0, 0, 0, 0);
    add(LW, 0, 1, 3, 0, 0, 0, 0, 0); add(LW, 0, 1, 4, 0, 0, 1, 0, 0);
    add(SW, 0, 1, 0, 1, 1, 0, 0, 0); add(SW, 0, 0, 1, 0, 0, 0, 0, 0); add(SW, 0, 0, 2, 0, 0, 0, 0, 0);
    add(SW, 0, 0, 5, 0, 0, 0, 1, 0); add(SW, 0, 0, 5, 0, 0, 0, 1, 0); add(SW, 0, 0, 5, 0, 0, 0, 1, 0);
    add(SW, 0, 1, 5, 0, 0, 0, 1, 0);
    add(BEQ, 1, 0, 0, 0, 0, 0, 0, 0); add(BEQ, 1, 0, 0, 0, 0, 0, 0, 0); add(BEQ, 1, 1, 0, 1, 1, 0, 0, 0);
    add(BEQ, 1, 0, 1, 0, 0, 0, 0, 0); add(BEQ, 1, 0, 8, 1, 0, 0, 0, 0);
    add(BEQ, 0, 1, 0, 1, 1, 0, 0, 0); add(BEQ, 0, 0, 1, 0, 0, 0, 0, 0); add(BEQ, 0, 0, 8, 0, 0, 0, 0, 0);
    add(RT, 0, 1, 0, 1, 1, 0, 0, 0); add(RT, 0, 0, 1, 0, 0, 0, 0, 0); add(RT, 0, 0, 6, 0, 0, 0, 0, 0);
    add(RT, 0, 0, 7, 0, 0, 1, 0, 0);
    add(JMP, 0, 1, 0, 1, 1, 0, 0, 0); add(JMP, 0, 0, 1, 0, 0, 0, 0, 0); add(JMP, 0, 0, 11, 1, 0, 0, 0, 0);
    add(ADDI, 0, 1, 0, 1, 1, 0, 0, 0); add(ADDI, 0, 0, 1, 0, 0, 0, 0, 0); add(ADDI, 0, 0, 9, 0, 0, 0, 0, 0);
    add(ADDI, 0, 0, 10, 0, 0, 1, 0, 0);
    add(BAD, 0, 1, 0, 1, 1, 0, 0, 0); add(BAD, 0, 0, 1, 0, 0, 0, 0, 1); add(BAD, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    do_reset();
    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].z, vecs[i].mr);
      check($sformatf("vec%0d", i), {28'(state_dbg), pc_en, ir_write, reg_write, mem_write, illegal_op},
            {28'(vecs[i].st), vecs[i].pc, vecs[i].ir, vecs[i].rw, vecs[i].mw, vecs[i].il});
      advance();
    end
    do_reset();
    apply(SW, 0, 1); advance();
    apply(SW, 0, 0); advance();
    apply(SW, 0, 0); advance();
    mem_ready = 1'b0;
    @(negedge clk);
    check("memwr_before_rst", {state_dbg, mem_write, iord}, {4'd5, 1'b1, 1'b1});
    #2 rst_n = 1'b0;
    #1 check("memwr_rst_async", 32'(dut_o), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mst = 0; plan = {};
    apply(SW, 0, 0); advance();
    apply(SW, 0, 0); advance();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] o;
      o = op;
      if (mst == 0) begin
        case ($urandom_range(0, 6))
          0: o = LW; 1: o = SW; 2: o = RT; 3: o = BEQ; 4: o = ADDI; 5: o = JMP;
          default: o = 6'($urandom);
        endcase
      end
      apply(o, 1'($urandom), $urandom_range(0, 3) != 0);
      advance();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
